free_rsp_merger: RTL

FREE_RSP_MERGER -- requirements
Module: free_rsp_merger

---
 rtl/free_rsp_merger.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/free_rsp_merger.sv
// Merges dispatcher reject responses and or_tree free completions into one free response FIFO write port.
// Optional stats counters (drop_count, merged_count) are built when FREE_RSP_MERGE_STATS_EN is defined.
`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif
`ifndef FAIL_REASON_WIDTH
`define FAIL_REASON_WIDTH 4
`endif

module free_rsp_queue #(
  parameter int DEPTH = 4,
  parameter int EW    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [EW-1:0]              din,
  input  logic                       pop,
  output logic [EW-1:0]              head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          full, accept;

  assign full   = (count == FULL_LVL);
  // a pop on the same edge frees the slot, so a full queue still accepts
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;
  assign head   = mem[rptr];

  always_ff @(posedge clk)
    if (accept) mem[wptr] <= din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (accept) wptr <= wptr + AW'(1);
      if (pop)    rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(accept) - (AW+1)'(pop);
    end
  end
endmodule

module free_rsp_merger #(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          disp_rsp_valid,
  input  logic [`REQ_ID_WIDTH-1:0]      disp_rsp_id,
  input  logic                          disp_rsp_fail,
  input  logic [`FAIL_REASON_WIDTH-1:0] disp_rsp_fail_reason,
  input  logic                          tree_rsp_valid,
  input  logic [`REQ_ID_WIDTH-1:0]      tree_rsp_id,
  input  logic                          tree_rsp_fail,
  input  logic [`FAIL_REASON_WIDTH-1:0] tree_rsp_fail_reason,
  output logic                          free_rsp_write_en,
  output logic [`REQ_ID_WIDTH-1:0]      free_rsp_id,
  output logic                          free_rsp_fail,
  output logic [`FAIL_REASON_WIDTH-1:0] free_rsp_fail_reason,
  input  logic                          free_rsp_fifo_almost_full,
  output logic                          merger_almost_full,
`ifdef FREE_RSP_MERGE_STATS_EN
  output logic [15:0]                   drop_count,
  output logic [31:0]                   merged_count,
`endif
  output logic                          overflow_sticky
);
  typedef struct packed {
    logic [`REQ_ID_WIDTH-1:0]      id;
    logic                          fail;
    logic [`FAIL_REASON_WIDTH-1:0] reason;
  } rsp_t;

  localparam int NSRC = 2;  // 0 = dispatcher, 1 = or_tree
  localparam int EW   = $bits(rsp_t);
  localparam int CW   = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] AF_LVL = CW'(QUEUE_DEPTH - 1);

  logic [NSRC-1:0]         src_vld, pop, drop, ne;
  rsp_t [NSRC-1:0]         src_data, head;
  logic [NSRC-1:0][CW-1:0] cnt;
  logic [NSRC-1:0]         grant;
  logic                    last_tree;
  rsp_t                    out_q;

  assign src_vld  = {tree_rsp_valid, disp_rsp_valid};
  assign src_data = {rsp_t'{tree_rsp_id, tree_rsp_fail, tree_rsp_fail_reason},
                     rsp_t'{disp_rsp_id, disp_rsp_fail, disp_rsp_fail_reason}};

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    free_rsp_queue #(.DEPTH(QUEUE_DEPTH), .EW(EW)) u_q (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (src_vld[g]),
      .din   (src_data[g]),
      .pop   (pop[g]),
      .head  (head[g]),
      .count (cnt[g]),
      .drop  (drop[g])
    );
    assign ne[g] = (cnt[g] != '0);
  end

  // round-robin between the two sources; no grant while the downstream FIFO is nearly full
  always_comb begin
    grant = '0;
    if (!free_rsp_fifo_almost_full) begin
      if (&ne) grant = last_tree ? 2'b01 : 2'b10;
      else     grant = ne;
    end
  end
  assign pop = grant;

  assign merger_almost_full = free_rsp_fifo_almost_full ||
                              (cnt[0] >= AF_LVL) || (cnt[1] >= AF_LVL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_tree         <= 1'b1;
      free_rsp_write_en <= 1'b0;
      out_q             <= '0;
      overflow_sticky   <= 1'b0;
    end else begin
      if (|grant) last_tree <= grant[1];
      free_rsp_write_en <= |grant;
      out_q             <= grant[0] ? head[0] : grant[1] ? head[1] : '0;
      if (|drop) overflow_sticky <= 1'b1;
    end
  end

  assign free_rsp_id          = out_q.id;
  assign free_rsp_fail        = out_q.fail;
  assign free_rsp_fail_reason = out_q.reason;

`ifdef FREE_RSP_MERGE_STATS_EN
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, drop_count} + 17'(drop[0]) + 17'(drop[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count   <= '0;
      merged_count <= '0;
    end else begin
      drop_count   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      merged_count <= merged_count + 32'(free_rsp_write_en);
    end
  end
`endif
endmodule
